// File: rtl/jtpang_colmix.sv
// Pang palette RAM + colour mixer: 2-pixel-enable video latency, 1-clk CPU read; no backpressure (CPU port always accepts).
// Define JTPANG_PALCLR_EN to clear the palette after reset (busy high while clearing).
module jtpang_colmix #(
    parameter int CLR_LAST = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pxl_cen,
    input  logic [10:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_rnw,
    input  logic        pal_cs,
    output logic [7:0]  pal_dout,
    input  logic [9:0]  scr_pxl,
    input  logic [7:0]  obj_pxl,
    input  logic        LHBL,
    input  logic        LVBL,
    output logic        LHBL_dly,
    output logic        LVBL_dly,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        busy
);

    logic [7:0] ram_even [0:1023];
    logic [7:0] ram_odd  [0:1023];

    logic       clearing;
    logic [9:0] clr_addr;

`ifdef JTPANG_PALCLR_EN
    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    localparam logic [9:0] CLR_LAST_W = 10'(CLR_LAST);

    state_t     state_q, state_d;
    logic [9:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == ST_CLEAR) begin
            cnt_d = cnt_q + 10'd1;
            if (cnt_q == CLR_LAST_W) state_d = ST_RUN;
        end
    end

    assign clearing = (state_q == ST_CLEAR);
    assign clr_addr = cnt_q;
`else
    localparam int unused_clr_last = CLR_LAST;

    assign clearing = 1'b0;
    assign clr_addr = '0;
`endif

    assign busy = clearing;

    // Clearing owns both write ports; CPU writes during that window are lost.
    logic       cpu_we, we_even, we_odd;
    logic [9:0] wr_addr;
    logic [7:0] wr_dat;

    assign cpu_we  = pal_cs & ~cpu_rnw & ~clearing;
    assign we_even = clearing | (cpu_we & ~cpu_addr[0]);
    assign we_odd  = clearing | (cpu_we &  cpu_addr[0]);
    assign wr_addr = clearing ? clr_addr : cpu_addr[10:1];
    assign wr_dat  = clearing ? 8'h00 : cpu_dout;

    always_ff @(posedge clk) begin
        if (we_even) ram_even[wr_addr] <= wr_dat;
        if (we_odd)  ram_odd[wr_addr]  <= wr_dat;
    end

    logic [7:0] cpu_rd_byte;
    logic [7:0] pal_dout_q, pal_dout_d;

    assign cpu_rd_byte = cpu_addr[0] ? ram_odd[cpu_addr[10:1]] : ram_even[cpu_addr[10:1]];

    always_comb begin
        pal_dout_d = pal_dout_q;
        if (pal_cs) pal_dout_d = clearing ? 8'h00 : cpu_rd_byte;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pal_dout_q <= '0;
        else        pal_dout_q <= pal_dout_d;
    end

    assign pal_dout = pal_dout_q;

    // Object colour 15 is see-through and lets the scroll layer show.
    logic [9:0]  mix_idx;
    logic [9:0]  idx1_q;
    logic        hbl1_q, vbl1_q, hbl2_q, vbl2_q;
    logic [11:0] rgb_q, rgb_d;

    assign mix_idx = (obj_pxl[3:0] != 4'hF) ? {2'b00, obj_pxl} : scr_pxl;

    always_comb begin
        rgb_d = 12'h000;
        if (hbl1_q && vbl1_q && !clearing)
            rgb_d = {ram_odd[idx1_q][3:0], ram_even[idx1_q]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx1_q <= '0;
            hbl1_q <= 1'b0;
            vbl1_q <= 1'b0;
            hbl2_q <= 1'b0;
            vbl2_q <= 1'b0;
            rgb_q  <= '0;
        end else if (pxl_cen) begin
            idx1_q <= mix_idx;
            hbl1_q <= LHBL;
            vbl1_q <= LVBL;
            hbl2_q <= hbl1_q;
            vbl2_q <= vbl1_q;
            rgb_q  <= rgb_d;
        end
    end

    assign LHBL_dly = hbl2_q;
    assign LVBL_dly = vbl2_q;
    assign red      = rgb_q[11:8];
    assign green    = rgb_q[7:4];
    assign blue     = rgb_q[3:0];

endmodule

// File: tb/tb_jtpang_colmix.sv
// Directed bench for jtpang_colmix: palette access, pixel mixing, blanking, collision, reset.
module tb_jtpang_colmix;

    logic        clk;
    logic        rst_n;
    logic        pxl_cen;
    logic [10:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_rnw;
    logic        pal_cs;
    logic [7:0]  pal_dout;
    logic [9:0]  scr_pxl;
    logic [7:0]  obj_pxl;
    logic        LHBL, LVBL;
    logic        LHBL_dly, LVBL_dly;
    logic [3:0]  red, green, blue;
    logic        busy;

    int vectors;
    int miscompares;

    jtpang_colmix #(.CLR_LAST(1023)) dut (
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_rnw(cpu_rnw),
        .pal_cs(pal_cs), .pal_dout(pal_dout),
        .scr_pxl(scr_pxl), .obj_pxl(obj_pxl),
        .LHBL(LHBL), .LVBL(LVBL), .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly),
        .red(red), .green(green), .blue(blue), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [11:0] rgb = {red, green, blue};

    task automatic cpu_wr(input logic [10:0] a, input logic [7:0] d);
        cpu_addr = a; cpu_dout = d; cpu_rnw = 1'b0; pal_cs = 1'b1;
        @(negedge clk);
        pal_cs = 1'b0; cpu_rnw = 1'b1;
    endtask

    task automatic cpu_rd(input logic [10:0] a, output logic [7:0] d);
        cpu_addr = a; cpu_rnw = 1'b1; pal_cs = 1'b1;
        @(negedge clk);
        d = pal_dout;
        pal_cs = 1'b0;
    endtask

    task automatic pix(input logic [7:0] o, input logic [9:0] s, input logic hb, input logic vb);
        obj_pxl = o; scr_pxl = s; LHBL = hb; LVBL = vb; pxl_cen = 1'b1;
        @(negedge clk);
        pxl_cen = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        logic exp_busy;
`ifdef JTPANG_PALCLR_EN
        exp_busy = 1'b1;
`else
        exp_busy = 1'b0;
`endif
        rst_n = 1'b0;
        #3;
        vectors++;
        if (pal_dout !== 8'h00) begin miscompares++; $display("FAIL reset_pal_dout: got %h want 00", pal_dout); end
        vectors++;
        if (rgb !== 12'h000) begin miscompares++; $display("FAIL reset_rgb: got %h want 000", rgb); end
        vectors++;
        if ({LHBL_dly, LVBL_dly} !== 2'b00) begin miscompares++; $display("FAIL reset_blank_dly: got %b want 00", {LHBL_dly, LVBL_dly}); end
        vectors++;
        if (busy !== exp_busy) begin miscompares++; $display("FAIL reset_busy: got %b want %b", busy, exp_busy); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

`ifdef JTPANG_PALCLR_EN
    task automatic test_clear;
        int n;
        int bad;
        logic [7:0] d;
        repeat (500) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL clear_midreset_busy: got %b want 1", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 3000) begin
            if (n == 10) begin cpu_addr = 11'h010; cpu_dout = 8'h77; cpu_rnw = 1'b0; pal_cs = 1'b1; end
            if (n == 11) begin pal_cs = 1'b0; cpu_rnw = 1'b1; end
            n++;
            @(negedge clk);
        end
        vectors++;
        if (n != 1024) begin miscompares++; $display("FAIL clear_busy_len: got %0d clks want 1024", n); end
        cpu_rd(11'h010, d);
        vectors++;
        if (d !== 8'h00) begin miscompares++; $display("FAIL clear_dropped_write: got %h want 00", d); end
        bad = 0;
        for (int a = 0; a < 2048; a++) begin
            cpu_rd(11'(a), d);
            if (d !== 8'h00) bad++;
        end
        vectors++;
        if (bad != 0) begin miscompares++; $display("FAIL clear_all_zero: got %0d nonzero bytes want 0", bad); end
    endtask
`endif

    task automatic test_rw;
        logic [7:0] d;
        cpu_wr(11'h123, 8'h5A);
        cpu_wr(11'h122, 8'hC3);
        cpu_rd(11'h123, d);
        vectors++;
        if (d !== 8'h5A) begin miscompares++; $display("FAIL rw_odd: got %h want 5a", d); end
        repeat (2) @(negedge clk);
        vectors++;
        if (pal_dout !== 8'h5A) begin miscompares++; $display("FAIL rw_hold: got %h want 5a", pal_dout); end
        cpu_rd(11'h122, d);
        vectors++;
        if (d !== 8'hC3) begin miscompares++; $display("FAIL rw_even: got %h want c3", d); end
    endtask

    task automatic test_priority;
        cpu_wr(11'h024, 8'h96);
        cpu_wr(11'h025, 8'h03);
        cpu_wr(11'h7E4, 8'h00);
        cpu_wr(11'h7E5, 8'h0F);
        pix(8'h12, 10'h3F2, 1'b1, 1'b1);
        vectors++;
        if ({LHBL_dly, rgb} !== 13'h0000) begin miscompares++; $display("FAIL prio_latency: got %h want 0000", {LHBL_dly, rgb}); end
        pix(8'h1F, 10'h3F2, 1'b1, 1'b1);
        vectors++;
        if (rgb !== 12'h396) begin miscompares++; $display("FAIL prio_obj: got %h want 396", rgb); end
        vectors++;
        if ({LHBL_dly, LVBL_dly} !== 2'b11) begin miscompares++; $display("FAIL prio_blank_dly: got %b want 11", {LHBL_dly, LVBL_dly}); end
        pix(8'h12, 10'h3F2, 1'b1, 1'b1);
        vectors++;
        if (rgb !== 12'hF00) begin miscompares++; $display("FAIL prio_scr: got %h want f00", rgb); end
        obj_pxl = 8'h1F;
        repeat (3) @(negedge clk);
        vectors++;
        if (rgb !== 12'hF00) begin miscompares++; $display("FAIL prio_hold: got %h want f00", rgb); end
    endtask

    task automatic test_blanking;
        pix(8'h12, 10'h3F2, 1'b1, 1'b1);
        pix(8'h12, 10'h3F2, 1'b0, 1'b1);
        vectors++;
        if ({LHBL_dly, rgb} !== {1'b1, 12'h396}) begin miscompares++; $display("FAIL blank_h_before: got %h want 1396", {LHBL_dly, rgb}); end
        pix(8'h12, 10'h3F2, 1'b1, 1'b1);
        vectors++;
        if ({LHBL_dly, rgb} !== {1'b0, 12'h000}) begin miscompares++; $display("FAIL blank_h_active: got %h want 0000", {LHBL_dly, rgb}); end
        pix(8'h12, 10'h3F2, 1'b1, 1'b0);
        vectors++;
        if ({LHBL_dly, rgb} !== {1'b1, 12'h396}) begin miscompares++; $display("FAIL blank_h_after: got %h want 1396", {LHBL_dly, rgb}); end
        pix(8'h12, 10'h3F2, 1'b1, 1'b1);
        vectors++;
        if ({LVBL_dly, rgb} !== {1'b0, 12'h000}) begin miscompares++; $display("FAIL blank_v_active: got %h want 0000", {LVBL_dly, rgb}); end
        pix(8'h12, 10'h3F2, 1'b1, 1'b1);
        vectors++;
        if ({LVBL_dly, rgb} !== {1'b1, 12'h396}) begin miscompares++; $display("FAIL blank_v_after: got %h want 1396", {LVBL_dly, rgb}); end
    endtask

    task automatic test_collision;
        cpu_wr(11'h00A, 8'h12);
        cpu_wr(11'h00B, 8'h07);
        pix(8'h05, 10'h000, 1'b1, 1'b1);
        obj_pxl = 8'h05; pxl_cen = 1'b1;
        cpu_addr = 11'h00A; cpu_dout = 8'hAB; cpu_rnw = 1'b0; pal_cs = 1'b1;
        @(negedge clk);
        pxl_cen = 1'b0; pal_cs = 1'b0; cpu_rnw = 1'b1;
        @(negedge clk);
        vectors++;
        if (rgb !== 12'h712) begin miscompares++; $display("FAIL collision_old: got %h want 712", rgb); end
        pix(8'h05, 10'h000, 1'b1, 1'b1);
        vectors++;
        if (rgb !== 12'h7AB) begin miscompares++; $display("FAIL collision_new: got %h want 7ab", rgb); end
    endtask

    task automatic test_async_reset;
        logic [7:0] d;
        cpu_rd(11'h123, d);
        pix(8'h12, 10'h3F2, 1'b1, 1'b1);
        pix(8'h12, 10'h3F2, 1'b1, 1'b1);
        vectors++;
        if ({pal_dout, rgb} !== {8'h5A, 12'h396}) begin miscompares++; $display("FAIL areset_pre: got %h want 5a396", {pal_dout, rgb}); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({pal_dout, rgb, LHBL_dly, LVBL_dly} !== 22'h0) begin
            miscompares++;
            $display("FAIL areset_outputs: got %h want 000000", {pal_dout, rgb, LHBL_dly, LVBL_dly});
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        pxl_cen = 1'b0; cpu_addr = '0; cpu_dout = '0; cpu_rnw = 1'b1; pal_cs = 1'b0;
        scr_pxl = '0; obj_pxl = 8'h0F; LHBL = 1'b0; LVBL = 1'b0;
        test_reset;
`ifdef JTPANG_PALCLR_EN
        test_clear;
`endif
        test_rw;
        test_priority;
        test_blanking;
        test_collision;
        test_async_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
